// File: rtl/ir_temp_fetch.sv
// Periodically reads eight IR temperature words over a req/ack port into shadow registers,
// then publishes them as one atomic set (optionally on the vsync falling edge) with max/health flags.
module ir_temp_fetch #(
  parameter logic [23:0] BASE_ADDR   = 24'h002400,
  parameter logic [31:0] SCAN_DIV    = 32'd2_500_000,
  parameter logic [15:0] ACK_TIMEOUT = 16'd255,
  parameter bit          SYNC_COMMIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] temp_0_16,
  output logic [15:0] temp_1_16,
  output logic [15:0] temp_2_16,
  output logic [15:0] temp_3_16,
  output logic [15:0] temp_4_16,
  output logic [15:0] temp_5_16,
  output logic [15:0] temp_6_16,
  output logic [15:0] temp_7_16,
  output logic [15:0] max_temp,
  output logic [2:0]  max_idx,
  output logic        frame_valid,
  output logic        rd_err,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PEND, COMMIT} state_t;

  state_t      state;
  logic [31:0] timer;
  logic        tick;
  logic [2:0]  ch;
  logic [15:0] to_cnt;
  logic        vs_d;
  logic [15:0] shadow [8];
  logic [15:0] temp_q [8];
  logic [15:0] max_val;
  logic [2:0]  max_ch;

  assign tick = (timer == 32'd0);

  assign temp_0_16 = temp_q[0];
  assign temp_1_16 = temp_q[1];
  assign temp_2_16 = temp_q[2];
  assign temp_3_16 = temp_q[3];
  assign temp_4_16 = temp_q[4];
  assign temp_5_16 = temp_q[5];
  assign temp_6_16 = temp_q[6];
  assign temp_7_16 = temp_q[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= SCAN_DIV - 32'd1;
    else if (tick) timer <= SCAN_DIV - 32'd1;
    else timer <= timer - 32'd1;
  end

  // Strict greater-than keeps the lowest channel on ties.
  always_comb begin
    max_val = shadow[0];
    max_ch  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (shadow[i] > max_val) begin
        max_val = shadow[i];
        max_ch  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= 3'd0;
      to_cnt      <= 16'd0;
      vs_d        <= 1'b1;
      mem_req     <= 1'b0;
      mem_addr    <= 24'd0;
      max_temp    <= 16'd0;
      max_idx     <= 3'd0;
      frame_valid <= 1'b0;
      rd_err      <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 16'd0;
        temp_q[i] <= 16'd0;
      end
    end else begin
      vs_d <= vs;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            ch    <= 3'd0;
            state <= REQ;
          end
        end
        REQ: begin
          mem_req  <= 1'b1;
          mem_addr <= BASE_ADDR + {21'd0, ch};
          to_cnt   <= 16'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // A timed-out channel keeps its previous shadow value.
          if (mem_ack || to_cnt == ACK_TIMEOUT) begin
            if (mem_ack) shadow[ch] <= mem_rdata;
            else rd_err <= 1'b1;
            mem_req <= 1'b0;
            if (ch == 3'd7) state <= PEND;
            else begin
              ch    <= ch + 3'd1;
              state <= REQ;
            end
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        PEND: begin
          if (!SYNC_COMMIT || (vs_d && !vs)) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < 8; i++) temp_q[i] <= shadow[i];
          frame_valid <= 1'b1;
          max_temp    <= max_val;
          max_idx     <= max_ch;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_temp_fetch.sv
// Bench for ir_temp_fetch: two instances (immediate and vsync-aligned commit) fed by a
// behavioural memory responder; results checked against a set-level reference model.
module tb_ir_temp_fetch;

  localparam logic [23:0] BASE = 24'h002400;
  localparam int DIV0 = 16;
  localparam int DIV1 = 100;

  logic clk = 1'b0;
  logic rst;
  logic vs;
  logic [1:0] req, ack;
  logic [1:0][23:0] addr;
  logic [1:0][15:0] rdata;
  logic [7:0][15:0] t0, t1;
  logic [15:0] mt0, mt1;
  logic [2:0] mi0, mi1;
  logic fv0, fv1, re0, re1, ov0, ov1;

  int checks = 0;
  int failures = 0;
  int cyc;

  int ack_delay [2];
  int noack [2];
  bit extra_ack [2];
  logic [7:0][15:0] mdata [2];
  int hi_cnt [2];
  bit acked [2];
  bit prev_req [2];
  int acnt [2];
  int done [2];
  logic [23:0] alog [2][64];
  int hlog [2][64];

  ir_temp_fetch #(.BASE_ADDR(BASE), .SCAN_DIV(32'(DIV0)), .ACK_TIMEOUT(16'd255), .SYNC_COMMIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .vs(1'b1), .mem_req(req[0]), .mem_addr(addr[0]), .mem_ack(ack[0]),
    .mem_rdata(rdata[0]), .temp_0_16(t0[0]), .temp_1_16(t0[1]), .temp_2_16(t0[2]),
    .temp_3_16(t0[3]), .temp_4_16(t0[4]), .temp_5_16(t0[5]), .temp_6_16(t0[6]),
    .temp_7_16(t0[7]), .max_temp(mt0), .max_idx(mi0), .frame_valid(fv0), .rd_err(re0),
    .overrun(ov0));

  ir_temp_fetch #(.BASE_ADDR(BASE), .SCAN_DIV(32'(DIV1)), .ACK_TIMEOUT(16'd255), .SYNC_COMMIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .vs(vs), .mem_req(req[1]), .mem_addr(addr[1]), .mem_ack(ack[1]),
    .mem_rdata(rdata[1]), .temp_0_16(t1[0]), .temp_1_16(t1[1]), .temp_2_16(t1[2]),
    .temp_3_16(t1[3]), .temp_4_16(t1[4]), .temp_5_16(t1[5]), .temp_6_16(t1[6]),
    .temp_7_16(t1[7]), .max_temp(mt1), .max_idx(mi1), .frame_valid(fv1), .rd_err(re1),
    .overrun(ov1));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Memory: acks ack_delay cycles after req rises, never acks channel noack; driven on negedges.
  always @(negedge clk) begin : responder
    int ch;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ack[k] = 1'b0; rdata[k] = 16'd0; acked[k] = 1'b0; prev_req[k] = 1'b0;
        hi_cnt[k] = 0; acnt[k] = 0; done[k] = 0;
      end else begin
        ack[k] = 1'b0;
        if (req[k] && !prev_req[k]) begin
          if (acnt[k] < 64) alog[k][acnt[k]] = addr[k];
          acnt[k]++;
          hi_cnt[k] = 0;
          acked[k] = 1'b0;
        end
        if (req[k]) begin
          hi_cnt[k]++;
          ch = int'(addr[k] - BASE);
          if (!acked[k] && hi_cnt[k] == ack_delay[k] + 1 && ch != noack[k] && ch >= 0 && ch < 8) begin
            ack[k] = 1'b1;
            rdata[k] = mdata[k][ch];
            acked[k] = 1'b1;
          end
        end
        if (!req[k] && prev_req[k]) begin
          if (done[k] < 64) hlog[k][done[k]] = hi_cnt[k];
          done[k]++;
        end
        if (extra_ack[k]) begin
          ack[k] = 1'b1;
          rdata[k] = 16'hBEEF;
        end
        prev_req[k] = req[k];
      end
    end
  end

  // Reference: largest value, then the first channel holding it.
  function automatic logic [18:0] ref_max(input logic [7:0][15:0] v);
    int best = 0;
    int idx = 0;
    for (int i = 0; i < 8; i++) if (int'(v[i]) > best) best = int'(v[i]);
    for (int i = 7; i >= 0; i--) if (int'(v[i]) == best) idx = i;
    return {3'(idx), 16'(best)};
  endfunction

  task automatic gen_round(input int k, input bit allow_noack);
    for (int i = 0; i < 8; i++)
      mdata[k][i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3) * 1000) : 16'($urandom);
    noack[k] = (allow_noack && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target, input int budget);
    int n = 0;
    while (done[k] < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done[k] < target) begin
      failures++;
      $display("[TB] FAIL wait_done dut%0d: got %0d channel reads, need %0d", k, done[k], target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vs = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({req, fv0, fv1, re0, re1, ov0, ov1} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b, need 0", {req, fv0, fv1, re0, re1, ov0, ov1});
    end
    checks++;
    if (t0 !== '0 || t1 !== '0) begin
      failures++;
      $display("[TB] FAIL reset_temps: got %h / %h, need 0", t0, t1);
    end
    checks++;
    if (addr !== '0 || {mt0, mt1, mi0, mi1} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_addr_max: got addr %h max %h %h idx %0d %0d, need 0", addr, mt0, mt1, mi0, mi1);
    end
  endtask

  task automatic test_basic();
    int n = 0;
    logic [7:0][15:0] expv;
    for (int i = 0; i < 8; i++) begin
      mdata[0][i] = 16'(100 + 10 * i);
      expv[i] = 16'(100 + 10 * i);
    end
    ack_delay[0] = 1;
    noack[0] = -1;
    do_reset();
    while (!req[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req[0] || (cyc != DIV0 && cyc != DIV0 + 1)) begin
      failures++;
      $display("[TB] FAIL first_req_time: req=%b at cycle %0d, need 1 at cycle %0d..%0d", req[0], cyc, DIV0, DIV0 + 1);
    end
    checks++;
    if (addr[0] !== BASE) begin
      failures++;
      $display("[TB] FAIL first_req_addr: got %h, need %h", addr[0], BASE);
    end
    wait_done(0, 8, 200);
    checks++;
    if (t0 !== '0 || fv0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_pre_commit: got temps %h fv %b, need 0 0", t0, fv0);
    end
    @(posedge clk); #1;
    checks++;
    if (t0 !== expv) begin
      failures++;
      $display("[TB] FAIL basic_temps: got %h, need %h", t0, expv);
    end
    checks++;
    if (mt0 !== 16'd170 || mi0 !== 3'd7 || fv0 !== 1'b1 || re0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_max_flags: got max %0d idx %0d fv %b err %b, need 170 7 1 0", mt0, mi0, fv0, re0);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (alog[0][i] !== BASE + 24'(i)) begin
        failures++;
        $display("[TB] FAIL basic_addr%0d: got %h, need %h", i, alog[0][i], BASE + 24'(i));
      end
    end
  endtask

  task automatic test_tie();
    mdata[0] = '0;
    mdata[0][0] = 16'd300;
    mdata[0][1] = 16'd250;
    mdata[0][2] = 16'd300;
    noack[0] = -1;
    do_reset();
    wait_done(0, 8, 200);
    @(posedge clk); #1;
    checks++;
    if (mt0 !== 16'd300 || mi0 !== 3'd0 || t0 !== mdata[0]) begin
      failures++;
      $display("[TB] FAIL tie_max: got max %0d idx %0d temps %h, need 300 0 %h", mt0, mi0, t0, mdata[0]);
    end
  endtask

  task automatic test_timeout();
    logic [7:0][15:0] expv;
    for (int i = 0; i < 8; i++) begin
      mdata[0][i] = 16'(500 + i);
      expv[i] = (i == 3) ? 16'd0 : 16'(500 + i);
    end
    noack[0] = 3;
    do_reset();
    wait_done(0, 8, 800);
    @(posedge clk); #1;
    checks++;
    if (t0 !== expv) begin
      failures++;
      $display("[TB] FAIL timeout_temps: got %h, need %h", t0, expv);
    end
    checks++;
    if (re0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_rd_err: got %b, need 1", re0);
    end
    checks++;
    if (hlog[0][3] != 256 || hlog[0][2] != 2) begin
      failures++;
      $display("[TB] FAIL timeout_req_len: got ch3 %0d ch2 %0d, need 256 2", hlog[0][3], hlog[0][2]);
    end
    checks++;
    if (mt0 !== 16'd507 || mi0 !== 3'd7) begin
      failures++;
      $display("[TB] FAIL timeout_max: got %0d idx %0d, need 507 7", mt0, mi0);
    end
    noack[0] = -1;
  endtask

  task automatic test_random();
    logic [7:0][15:0] expv = '0;
    bit exp_err = 1'b0;
    ack_delay[0] = 1;
    gen_round(0, 1'b1);
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) if (i != noack[0]) expv[i] = mdata[0][i];
      if (noack[0] >= 0) exp_err = 1'b1;
      wait_done(0, 8 * (r + 1), 800);
      if (r < 5) gen_round(0, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (t0 !== expv) begin
        failures++;
        $display("[TB] FAIL random%0d_temps: got %h, need %h", r, t0, expv);
      end
      checks++;
      if ({mi0, mt0} !== ref_max(expv) || re0 !== exp_err || fv0 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL random%0d_max_flags: got idx %0d max %0d err %b fv %b, need %h err %b fv 1",
                 r, mi0, mt0, re0, fv0, ref_max(expv), exp_err);
      end
    end
  endtask

  task automatic test_sync();
    int bad = 0;
    gen_round(1, 1'b0);
    ack_delay[1] = 1;
    do_reset();
    wait_done(1, 8, 400);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (t1 !== '0 || fv1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL sync_hold: got %0d cycles with changed outputs, need 0", bad);
    end
    vs = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (t1 !== '0 || fv1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sync_edge_cycle: got temps %h fv %b, need 0 0", t1, fv1);
    end
    @(posedge clk); #1;
    checks++;
    if (t1 !== mdata[1] || fv1 !== 1'b1 || {mi1, mt1} !== ref_max(mdata[1])) begin
      failures++;
      $display("[TB] FAIL sync_commit: got temps %h fv %b idx %0d max %0d, need %h 1 %h",
               t1, fv1, mi1, mt1, mdata[1], ref_max(mdata[1]));
    end
    vs = 1'b1;
  endtask

  task automatic test_overrun();
    int n = 0;
    int commit_cyc;
    gen_round(1, 1'b0);
    ack_delay[1] = 40;
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (ov1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_initial: got %b, need 0", ov1);
    end
    wait_done(1, 8, 1500);
    checks++;
    if (ov1 !== 1'b1 || t1 !== '0) begin
      failures++;
      $display("[TB] FAIL overrun_flag: got ov %b temps %h, need 1 0", ov1, t1);
    end
    vs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    commit_cyc = cyc;
    vs = 1'b1;
    checks++;
    if (t1 !== mdata[1] || {mi1, mt1} !== ref_max(mdata[1])) begin
      failures++;
      $display("[TB] FAIL overrun_commit: got %h idx %0d max %0d, need %h %h", t1, mi1, mt1, mdata[1], ref_max(mdata[1]));
    end
    while (!req[1] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req[1] || addr[1] !== BASE || (cyc % DIV1) > 1 || cyc - commit_cyc > DIV1 + 1) begin
      failures++;
      $display("[TB] FAIL overrun_next_scan: got req %b addr %h at cycle %0d (commit %0d), need req at next tick",
               req[1], addr[1], cyc, commit_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    while (acnt[1] < 14 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (acnt[1] < 14 || !req[1] || alog[1][13] !== BASE + 24'd5 || t1 !== mdata[1]) begin
      failures++;
      $display("[TB] FAIL midreset_setup: got reqs %0d req %b addr %h temps %h, need ch5 pending with %h",
               acnt[1], req[1], alog[1][13], t1, mdata[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req[1] !== 1'b0 || addr[1] !== 24'd0) begin
      failures++;
      $display("[TB] FAIL midreset_req: got req %b addr %h, need 0 0", req[1], addr[1]);
    end
    checks++;
    if (t1 !== '0 || {fv1, re1, ov1} !== 3'd0 || mt1 !== 16'd0 || mi1 !== 3'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got temps %h flags %b max %0d idx %0d, need 0",
               t1, {fv1, re1, ov1}, mt1, mi1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    extra_ack[1] = 1'b1;
    @(posedge clk); #1;
    extra_ack[1] = 1'b0;
    n = 0;
    while (!req[1] && n < 200) begin
      @(posedge clk); #1;
      if (t1 !== '0 || fv1 !== 1'b0) bad++;
      n++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL midreset_late_ack: got %0d cycles with changed outputs, need 0", bad);
    end
    checks++;
    if (!req[1] || (cyc != DIV1 && cyc != DIV1 + 1)) begin
      failures++;
      $display("[TB] FAIL midreset_next_tick: req %b at cycle %0d, need 1 at cycle %0d..%0d", req[1], cyc, DIV1, DIV1 + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    vs = 1'b1;
    ack_delay[0] = 1;
    ack_delay[1] = 1;
    noack[0] = -1;
    noack[1] = -1;
    extra_ack[0] = 1'b0;
    extra_ack[1] = 1'b0;
    mdata[0] = '0;
    mdata[1] = '0;
    test_reset();
    test_basic();
    test_tie();
    test_timeout();
    test_random();
    test_sync();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
